// File: rtl/adder_tree_seq_if.sv
// Operand stream in, reduced result out, for adder_tree_seq.
// master drives operands and result-ready; slave is the sequencer.
interface adder_tree_seq_if #(
    parameter int WIDTH = 17,
    parameter int ACC_W = 27,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             busy;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf, busy
    );
endinterface

// File: rtl/adder_tree_seq.sv
// Stream reducer: collects operands four at a time into lane registers,
// sums them with one 4-input adder tree and accumulates into a wide register.
module AdderTree_unsigned #(
    parameter int WIDTH = 17
) (
    input  logic [3:0][WIDTH-1:0] operands,
    output logic [WIDTH+1:0]      sum
);
    logic [WIDTH:0] pair_lo;
    logic [WIDTH:0] pair_hi;

    assign pair_lo = {1'b0, operands[0]} + {1'b0, operands[1]};
    assign pair_hi = {1'b0, operands[2]} + {1'b0, operands[3]};
    assign sum     = {1'b0, pair_lo} + {1'b0, pair_hi};
endmodule

module adder_tree_seq_lane #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Cleared after every tree pass so unfilled lanes contribute zero.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) q <= '0;
        else if (wr)       q <= d;
    end
endmodule

module adder_tree_seq #(
    parameter int WIDTH = 17,
    parameter int ACC_W = 27,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    adder_tree_seq_if.slave  bus
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {COLLECT, SUM, DONE} state_t;

    state_t                          state, state_nxt;
    logic [1:0]                      idx;
    logic [NUM_LANES-1:0][WIDTH-1:0] lanes;
    logic [NUM_LANES-1:0]            lane_wr;
    logic [ACC_W-1:0]                acc;
    logic [CNT_W-1:0]                count;
    logic                            ovf;
    logic                            last_seen;
    logic                            xfer;
    logic                            in_ready;
    logic                            out_valid;
    logic                            sum_en;
    logic                            out_xfer;
    logic [WIDTH+1:0]                tree_sum;
    logic [ACC_W:0]                  acc_add;

    assign xfer = bus.in_valid && (state == COLLECT);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign lane_wr[g] = xfer && (idx == 2'(g));
        adder_tree_seq_lane #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (lane_wr[g]),
            .clr   (sum_en),
            .d     (bus.in_data),
            .q     (lanes[g])
        );
    end

    AdderTree_unsigned #(.WIDTH(WIDTH)) u_tree (
        .operands (lanes),
        .sum      (tree_sum)
    );

    // Extra top bit of the add is the wrap indicator for the sticky flag.
    assign acc_add = {1'b0, acc} + (ACC_W+1)'(tree_sum);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sum_en    = 1'b0;
        out_xfer  = 1'b0;
        unique case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (bus.in_valid && (idx == 2'd3 || bus.in_last)) state_nxt = SUM;
            end
            SUM: begin
                sum_en    = 1'b1;
                state_nxt = last_seen ? DONE : COLLECT;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    out_xfer  = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            last_seen <= 1'b0;
        end else begin
            if (xfer) begin
                idx       <= idx + 2'd1;
                last_seen <= bus.in_last;
                if (count != '1) count <= count + CNT_W'(1);
            end
            if (sum_en) begin
                idx <= '0;
                acc <= acc_add[ACC_W-1:0];
                ovf <= ovf | acc_add[ACC_W];
            end
            if (out_xfer) begin
                acc       <= '0;
                count     <= '0;
                ovf       <= 1'b0;
                last_seen <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = acc;
    assign bus.out_count = count;
    assign bus.out_ovf   = ovf;
    assign bus.busy      = !(state == COLLECT && idx == 2'd0 && acc == '0);
endmodule

// File: tb/tb_adder_tree_seq.sv
// Bench for adder_tree_seq: two instances (default widths and a narrow
// ACC_W=19/CNT_W=3 one) share stimulus; a stream-level model predicts both.
module tb_adder_tree_seq;
    localparam int W  = 17;
    localparam int A0 = 27;
    localparam int C0 = 16;
    localparam int A1 = 19;
    localparam int C1 = 3;
    localparam logic [63:0] M0   = (64'd1 << A0) - 1;
    localparam logic [63:0] M1   = (64'd1 << A1) - 1;
    localparam logic [63:0] CMX0 = (64'd1 << C0) - 1;
    localparam logic [63:0] CMX1 = (64'd1 << C1) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    always #5 clk = ~clk;

    adder_tree_seq_if #(.WIDTH(W), .ACC_W(A0), .CNT_W(C0)) bus0 ();
    adder_tree_seq_if #(.WIDTH(W), .ACC_W(A1), .CNT_W(C1)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.in_last   = in_last;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.in_last   = in_last;
    assign bus1.out_ready = out_ready;

    adder_tree_seq #(.WIDTH(W), .ACC_W(A0), .CNT_W(C0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    adder_tree_seq #(.WIDTH(W), .ACC_W(A1), .CNT_W(C1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    typedef struct {
        logic [63:0] sum0, sum1, cnt0, cnt1;
        logic [63:0] ovf0, ovf1;
    } res_t;

    // Pending beats, expected results and the protocol-level model state.
    logic [W-1:0] bd_q[$];
    bit           bl_q[$];
    res_t         exp_q[$];
    int           n_lane, hold, bp_cycles, vmode, rmode;
    bit           sum_cyc, done_f, last_pend;
    logic [63:0]  ssum, scnt;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input bit l);
        bd_q.push_back(d);
        bl_q.push_back(l);
    endtask

    task automatic push_n(input int n, input logic [W-1:0] d);
        for (int i = 0; i < n; i++) push(d, i == n - 1);
    endtask

    task automatic model_clear();
        bd_q.delete(); bl_q.delete(); exp_q.delete();
        n_lane = 0; hold = 0; sum_cyc = 0; done_f = 0; last_pend = 0;
        ssum = '0; scnt = '0;
    endtask

    task automatic do_reset(input int cyc);
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (cyc) @(negedge clk);
        chk("rst_in_ready0",  64'(bus0.in_ready),  64'd1);
        chk("rst_out_valid0", 64'(bus0.out_valid), 64'd0);
        chk("rst_out_sum0",   64'(bus0.out_sum),   64'd0);
        chk("rst_out_count0", 64'(bus0.out_count), 64'd0);
        chk("rst_out_ovf0",   64'(bus0.out_ovf),   64'd0);
        chk("rst_busy0",      64'(bus0.busy),      64'd0);
        chk("rst_in_ready1",  64'(bus1.in_ready),  64'd1);
        chk("rst_out_valid1", 64'(bus1.out_valid), 64'd0);
        chk("rst_busy1",      64'(bus1.busy),      64'd0);
        rst_n = 1'b1;
        model_clear();
    endtask

    // One clock: check outputs against the model, drive next inputs, advance the model.
    task automatic step();
        bit   er, xfer;
        res_t r;
        @(negedge clk);
        er = !sum_cyc && !done_f;
        chk("in_ready0",  64'(bus0.in_ready),  64'(er));
        chk("in_ready1",  64'(bus1.in_ready),  64'(er));
        chk("out_valid0", 64'(bus0.out_valid), 64'(done_f));
        chk("out_valid1", 64'(bus1.out_valid), 64'(done_f));
        chk("busy0", 64'(bus0.busy),
            64'(sum_cyc || done_f || n_lane != 0 || (ssum & M0) != 0));
        chk("busy1", 64'(bus1.busy),
            64'(sum_cyc || done_f || n_lane != 0 || (ssum & M1) != 0));
        if (done_f && exp_q.size() > 0) begin
            chk("out_sum0",   64'(bus0.out_sum),   exp_q[0].sum0);
            chk("out_count0", 64'(bus0.out_count), exp_q[0].cnt0);
            chk("out_ovf0",   64'(bus0.out_ovf),   exp_q[0].ovf0);
            chk("out_sum1",   64'(bus1.out_sum),   exp_q[0].sum1);
            chk("out_count1", 64'(bus1.out_count), exp_q[0].cnt1);
            chk("out_ovf1",   64'(bus1.out_ovf),   exp_q[0].ovf1);
        end

        if (bd_q.size() > 0 && (vmode == 0 || $urandom_range(0, 2) != 0)) begin
            in_valid = 1'b1; in_data = bd_q[0]; in_last = bl_q[0];
        end else begin
            in_valid = 1'b0; in_data = W'($urandom); in_last = 1'($urandom_range(0, 1));
        end
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (done_f && hold < bp_cycles) begin
                    out_ready = 1'b0;
                    hold++;
                end else out_ready = 1'b1;
            end
        endcase

        xfer = in_valid && er;
        if (sum_cyc) begin
            sum_cyc = 0;
            done_f  = last_pend;
        end else if (done_f) begin
            if (out_ready) begin
                done_f = 0;
                hold   = 0;
                void'(exp_q.pop_front());
            end
        end else if (xfer) begin
            ssum = ssum + 64'(in_data);
            scnt = scnt + 64'd1;
            n_lane++;
            void'(bd_q.pop_front());
            void'(bl_q.pop_front());
            if (in_last) begin
                r.sum0 = ssum & M0;
                r.sum1 = ssum & M1;
                r.cnt0 = (scnt > CMX0) ? CMX0 : scnt;
                r.cnt1 = (scnt > CMX1) ? CMX1 : scnt;
                r.ovf0 = 64'(ssum > M0);
                r.ovf1 = 64'(ssum > M1);
                exp_q.push_back(r);
                ssum = '0;
                scnt = '0;
            end
            if (n_lane == 4 || in_last) begin
                sum_cyc   = 1;
                n_lane    = 0;
                last_pend = in_last;
            end
        end
    endtask

    task automatic run(input int lim);
        int c = 0;
        while ((bd_q.size() > 0 || sum_cyc || done_f) && c < lim) begin
            step();
            c++;
        end
        step();
    endtask

    initial begin
        vmode = 0; rmode = 0; bp_cycles = 0;
        model_clear();
        do_reset(2);

        push(17'd1, 0); push(17'd2, 0); push(17'd3, 0); push(17'd4, 1);
        run(40);
        push_n(9, 17'h1FFFF);
        run(60);
        push(17'h00005, 1);
        run(20);

        // Result held off in DONE while the next stream is already waiting.
        rmode = 2; bp_cycles = 6;
        push(17'd1, 0); push(17'd1, 1); push(17'd7, 0); push(17'd8, 1);
        run(60);
        rmode = 0;

        push_n(5, 17'h1FFFF); push(17'd3, 1);
        run(60);

        push(17'd9, 0); push(17'd9, 0); push(17'd9, 0);
        run(20);
        do_reset(2);
        repeat (3) step();
        push(17'd2, 0); push(17'd2, 1);
        run(20);

        for (int it = 0; it < 12; it++) begin
            vmode = 1;
            rmode = $urandom_range(0, 2);
            bp_cycles = $urandom_range(0, 4);
            for (int s = 0; s < 4; s++) begin
                int len;
                len = $urandom_range(1, 12);
                for (int b = 0; b < len; b++)
                    push(($urandom_range(0, 3) == 0) ? 17'h1FFFF : W'($urandom), b == len - 1);
            end
            run(400);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
